srffe_bank: RTL

- Parametrised bank of W independent RS flags; the next generation of the team's RS flip-flop primitive.
- Adds a configurable simultaneous-set/reset resolution, optional edge-sensitive set, per-channel auto-clear timeout, set-overflow sticky flags, rise pulses and a bank-wide synchronous clear.
- Used as the event/status flag register between front-end trigger logic and readout/interrupt logic.

---
 rtl/srffe_bank.sv | 103 ++++++++++
 1 files changed

// File: rtl/srffe_bank.sv
// Bank of W independent RS flags: configurable set/reset resolution, optional edge set, auto-clear timeout, sticky overflow, rise pulse.
// One clk edge from s/r/ena to q, q_rise and ovf; no backpressure, every edge is consumed.
module srffe_bank #(
  parameter int W       = 8,
  parameter int MODE    = 0,
  parameter int EDGE    = 0,
  parameter int TIMEOUT = 0,
  parameter int CW      = 16
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic [W-1:0] ena,
  input  logic [W-1:0] s,
  input  logic [W-1:0] r,
  input  logic         clr_all,
  output logic [W-1:0] q,
  output logic [W-1:0] q_rise,
  output logic [W-1:0] ovf,
  output logic         any_q
);

  for (genvar i = 0; i < W; i++) begin : g_ch
    logic se;
    logic re;
    logic tmo_hit;
    logic q_r;
    logic rise_r;
    logic ovf_r;
    logic nq;
    logic novf;

    assign re = ena[i] & r[i];

    if (EDGE != 0) begin : g_edge
      // History samples s regardless of ena and clr_all, so a masked edge is lost for good.
      logic s_d;
      always_ff @(posedge clk) begin
        if (!clrn) s_d <= 1'b0;
        else       s_d <= s[i];
      end
      assign se = ena[i] & s[i] & ~s_d;
    end else begin : g_level
      assign se = ena[i] & s[i];
    end

    if (TIMEOUT > 0) begin : g_tmo
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
      logic [CW-1:0] cnt;
      assign tmo_hit = q_r & (cnt == LAST);
      // Counter is zero whenever the flag is low; any set or reset restarts it.
      always_ff @(posedge clk) begin
        if (!clrn || clr_all)                 cnt <= '0;
        else if (se || re || !q_r || tmo_hit) cnt <= '0;
        else                                  cnt <= cnt + CW'(1);
      end
    end else begin : g_notmo
      assign tmo_hit = 1'b0;
    end

    always_comb begin
      nq   = q_r;
      novf = ovf_r;
      if (se && re) begin
        if (MODE == 1) begin
          nq   = 1'b0;
          novf = 1'b0;
        end else if (MODE == 2) begin
          nq = ~q_r;
        end else begin
          nq   = 1'b1;
          novf = ovf_r | q_r;
        end
      end else if (se) begin
        nq   = 1'b1;
        novf = ovf_r | q_r;
      end else if (re) begin
        nq   = 1'b0;
        novf = 1'b0;
      end else if (tmo_hit) begin
        nq = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!clrn || clr_all) begin
        q_r    <= 1'b0;
        rise_r <= 1'b0;
        ovf_r  <= 1'b0;
      end else begin
        q_r    <= nq;
        rise_r <= nq & ~q_r;
        ovf_r  <= novf;
      end
    end

    assign q[i]      = q_r;
    assign q_rise[i] = rise_r;
    assign ovf[i]    = ovf_r;
  end

  assign any_q = |q;

endmodule
